// File: rtl/pbus_timer_if.sv
// Peripheral strobe bus between a CPU initiator (master) and a register responder (slave).
interface pbus_timer_if;
  logic       p_wr_strobe;
  logic       p_rd_strobe;
  logic [7:0] p_addr;
  logic [7:0] p_dout;
  logic [7:0] p_din;
  logic       p_rd_done;

  modport master (
    output p_wr_strobe, p_rd_strobe, p_addr, p_dout,
    input  p_din, p_rd_done
  );

  modport slave (
    input  p_wr_strobe, p_rd_strobe, p_addr, p_dout,
    output p_din, p_rd_done
  );
endinterface

// File: rtl/pbus_timer.sv
// Peripheral-bus 8-bit prescaled timer with compare match, overflow flags and irq.
// Optional PBUS_TIMER_RD_CLEAR_EN: a completed STATUS read clears the bits it returned.
module pbus_timer #(
  parameter logic [7:0]  BASE_ADDR    = 8'h10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  pbus_timer_if.slave bus,
  output logic        o_irq
);

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lat;
  logic [LW-1:0]   w_lat_nxt;
  logic [DW-1:0]   r_cap;
  logic [DW-1:0]   w_cap_nxt;
  logic [DW-1:0]   r_din;
  logic            r_rd_done;
  logic            r_irq;

  logic [2:0]      r_ctrl;
  logic [DW-1:0]   r_presc;
  logic [DW-1:0]   r_count;
  logic [DW-1:0]   r_compare;
  logic [1:0]      r_status;
  logic [DW-1:0]   r_presc_cnt;

  logic [DW-1:0]   w_off;
  logic            w_hit;
  logic            w_wr_ctrl;
  logic            w_wr_presc;
  logic            w_wr_count;
  logic            w_wr_compare;
  logic            w_wr_status;
  logic [DW-1:0]   w_rdata;

  logic            w_tick;
  logic            w_match;
  logic            w_ovf;
  logic [2:0]      w_ctrl_nxt;
  logic [DW-1:0]   w_presc_nxt;
  logic [DW-1:0]   w_count_nxt;
  logic [DW-1:0]   w_compare_nxt;
  logic [DW-1:0]   w_presc_cnt_nxt;
  logic [1:0]      w_status_clr;
  logic [1:0]      w_status_nxt;

`ifdef PBUS_TIMER_RD_CLEAR_EN
  logic            r_cap_st;
  logic            w_cap_st_nxt;
`endif

  // Address decode; offsets below BASE_ADDR wrap to large values and miss.
  assign w_off        = bus.p_addr - BASE_ADDR;
  assign w_hit        = (w_off <= DW'(4));
  assign w_wr_ctrl    = bus.p_wr_strobe && (w_off == DW'(0));
  assign w_wr_presc   = bus.p_wr_strobe && (w_off == DW'(1));
  assign w_wr_count   = bus.p_wr_strobe && (w_off == DW'(2));
  assign w_wr_compare = bus.p_wr_strobe && (w_off == DW'(3));
  assign w_wr_status  = bus.p_wr_strobe && (w_off == DW'(4));

  always_comb begin
    w_rdata = '0;
    case (w_off)
      DW'(0):  w_rdata = {5'b0, r_ctrl};
      DW'(1):  w_rdata = r_presc;
      DW'(2):  w_rdata = r_count;
      DW'(3):  w_rdata = r_compare;
      DW'(4):  w_rdata = {6'b0, r_status};
      default: w_rdata = '0;
    endcase
  end

  // Read FSM next-state: capture in IDLE, count down in WAIT, one-cycle DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_lat_nxt    = r_lat;
    w_cap_nxt    = r_cap;
`ifdef PBUS_TIMER_RD_CLEAR_EN
    w_cap_st_nxt = r_cap_st;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.p_rd_strobe && w_hit) begin
          w_cap_nxt = w_rdata;
`ifdef PBUS_TIMER_RD_CLEAR_EN
          w_cap_st_nxt = (w_off == DW'(4));
`endif
          if (READ_LATENCY <= 1) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WAIT;
            w_lat_nxt   = LW'(READ_LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        w_lat_nxt = r_lat - LW'(1);
        if (r_lat <= LW'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timer and register next values; CPU writes beat same-cycle tick updates.
  always_comb begin
    w_tick   = r_ctrl[0] && (r_presc_cnt == r_presc);
    w_match  = w_tick && (r_count == r_compare);
    w_ovf    = w_tick && (r_count == 8'hFF) && !(w_match && r_ctrl[1]);

    w_ctrl_nxt    = w_wr_ctrl    ? bus.p_dout[2:0] : r_ctrl;
    w_presc_nxt   = w_wr_presc   ? bus.p_dout      : r_presc;
    w_compare_nxt = w_wr_compare ? bus.p_dout      : r_compare;

    w_presc_cnt_nxt = r_presc_cnt;
    if (w_wr_count)     w_presc_cnt_nxt = '0;
    else if (r_ctrl[0]) w_presc_cnt_nxt = w_tick ? '0 : r_presc_cnt + DW'(1);

    w_count_nxt = r_count;
    if (w_wr_count)  w_count_nxt = bus.p_dout;
    else if (w_tick) w_count_nxt = (w_match && r_ctrl[1]) ? '0 : r_count + DW'(1);

    w_status_clr = w_wr_status ? bus.p_dout[1:0] : 2'b00;
`ifdef PBUS_TIMER_RD_CLEAR_EN
    if ((r_state == ST_DONE) && r_cap_st) w_status_clr = w_status_clr | r_cap[1:0];
`endif
    w_status_nxt = (r_status & ~w_status_clr) | {w_ovf, w_match};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_lat       <= '0;
      r_cap       <= '0;
      r_din       <= '0;
      r_rd_done   <= 1'b0;
      r_irq       <= 1'b0;
      r_ctrl      <= '0;
      r_presc     <= '0;
      r_count     <= '0;
      r_compare   <= '0;
      r_status    <= '0;
      r_presc_cnt <= '0;
`ifdef PBUS_TIMER_RD_CLEAR_EN
      r_cap_st    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_lat       <= w_lat_nxt;
      r_cap       <= w_cap_nxt;
      r_din       <= (w_state_nxt == ST_DONE) ? w_cap_nxt : '0;
      r_rd_done   <= (w_state_nxt == ST_DONE);
      r_irq       <= w_ctrl_nxt[2] && (w_status_nxt != 2'b00);
      r_ctrl      <= w_ctrl_nxt;
      r_presc     <= w_presc_nxt;
      r_count     <= w_count_nxt;
      r_compare   <= w_compare_nxt;
      r_status    <= w_status_nxt;
      r_presc_cnt <= w_presc_cnt_nxt;
`ifdef PBUS_TIMER_RD_CLEAR_EN
      r_cap_st    <= w_cap_st_nxt;
`endif
    end
  end

  assign bus.p_din     = r_din;
  assign bus.p_rd_done = r_rd_done;
  assign o_irq         = r_irq;

endmodule

// File: tb/tb_pbus_timer.sv
// Bench for pbus_timer: two instances (READ_LATENCY 1 and 3) share one stimulus stream.
module tb_pbus_timer;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [7:0] addr;
  logic [7:0] dout;
  logic       irq1;
  logic       irq3;
  int         cyc;
  int         checks;
  int         errors;

  pbus_timer_if bus1 ();
  pbus_timer_if bus3 ();

  assign bus1.p_wr_strobe = wr;
  assign bus1.p_rd_strobe = rd;
  assign bus1.p_addr      = addr;
  assign bus1.p_dout      = dout;
  assign bus3.p_wr_strobe = wr;
  assign bus3.p_rd_strobe = rd;
  assign bus3.p_addr      = addr;
  assign bus3.p_dout      = dout;

  pbus_timer #(.BASE_ADDR(8'h10), .READ_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1), .o_irq(irq1));

  pbus_timer #(.BASE_ADDR(8'h10), .READ_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus3), .o_irq(irq3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // Reference timer: apply the tick rules once per tick over d enabled cycles.
  function automatic logic [9:0] model(input logic [2:0] ctrl, input logic [7:0] p,
                                       input logic [7:0] k, input logic [7:0] c, input int d);
    int         n;
    logic [7:0] cnt;
    logic [1:0] st;
    n   = ctrl[0] ? d / (int'(p) + 1) : 0;
    cnt = c;
    st  = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (cnt == k) st[0] = 1'b1;
      if (cnt == k && ctrl[1]) begin
        cnt = 8'h00;
      end else begin
        if (cnt == 8'hFF) st[1] = 1'b1;
        cnt = cnt + 8'h01;
      end
    end
    return {st, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    tick();
    wr   = 1'b1;
    addr = a;
    dout = d;
  endtask

  // Strobe a read and check both instances' done pulse position and data over 5 cycles.
  task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input bit hit,
                          input bit chk_irq, input bit exp_irq);
    logic       e1, e3;
    logic [7:0] d1, d3;
    tick();
    rd   = 1'b1;
    addr = a;
    if (chk_irq) begin
      checks++;
      if (irq1 !== exp_irq || irq3 !== exp_irq) begin
        errors++;
        $display("FAIL irq_at_read addr=%h got %b/%b exp %b", a, irq1, irq3, exp_irq);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      e1 = hit && (k == 1);
      e3 = hit && (k == 3);
      d1 = e1 ? exp : 8'h00;
      d3 = e3 ? exp : 8'h00;
      checks++;
      if (bus1.p_rd_done !== e1 || bus1.p_din !== d1) begin
        errors++;
        $display("FAIL rd_lat1 addr=%h k=%0d got done=%b din=%h exp done=%b din=%h",
                 a, k, bus1.p_rd_done, bus1.p_din, e1, d1);
      end
      checks++;
      if (bus3.p_rd_done !== e3 || bus3.p_din !== d3) begin
        errors++;
        $display("FAIL rd_lat3 addr=%h k=%0d got done=%b din=%h exp done=%b din=%h",
                 a, k, bus3.p_rd_done, bus3.p_din, e3, d3);
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    checks++;
    if (bus1.p_rd_done !== 1'b0 || bus1.p_din !== 8'h00 || irq1 !== 1'b0 ||
        bus3.p_rd_done !== 1'b0 || bus3.p_din !== 8'h00 || irq3 !== 1'b0) begin
      errors++;
      $display("FAIL %s got done=%b/%b din=%h/%h irq=%b/%b exp all 0", tag,
               bus1.p_rd_done, bus3.p_rd_done, bus1.p_din, bus3.p_din, irq1, irq3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0; addr = 8'h00; dout = 8'h00;
    idle(3);
    chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    idle(2);
    chk_outputs_zero("after_reset_outputs");
    for (int i = 0; i < 5; i++) read_chk(8'h10 + 8'(i), 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic setup(input logic [2:0] ctrl, input logic [7:0] p, input logic [7:0] k,
                       input logic [7:0] c, output int cw);
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h11, p);
    wr_reg(8'h13, k);
    wr_reg(8'h14, 8'h03);
    wr_reg(8'h12, c);
    wr_reg(8'h10, {5'b0, ctrl});
    cw = cyc;
  endtask

  task automatic timer_scenario(input logic [2:0] ctrl, input logic [7:0] p,
                                input logic [7:0] k, input logic [7:0] c, input int d);
    int         cw;
    logic [9:0] r;
    setup(ctrl, p, k, c, cw);
    idle(d);
    r = model(ctrl, p, k, c, cyc - cw);
    read_chk(8'h12, r[7:0], 1'b1, 1'b0, 1'b0);
    r = model(ctrl, p, k, c, cyc - cw);
    read_chk(8'h14, {6'b0, r[9:8]}, 1'b1, 1'b1, ctrl[2] && (r[9:8] != 2'b00));
  endtask

  task automatic test_match_irq();
    int cw;
    setup(3'b111, 8'h00, 8'h05, 8'h00, cw);
    idle(6);
    checks++;
    if (irq1 !== 1'b0 || irq3 !== 1'b0) begin
      errors++; $display("FAIL irq_before_match got %b/%b exp 0", irq1, irq3);
    end
    tick();
    checks++;
    if (irq1 !== 1'b1 || irq3 !== 1'b1) begin
      errors++; $display("FAIL irq_on_match got %b/%b exp 1", irq1, irq3);
    end
    wr_reg(8'h14, 8'h01);
    tick();
    checks++;
    if (irq1 !== 1'b0 || irq3 !== 1'b0) begin
      errors++; $display("FAIL irq_after_w1c got %b/%b exp 0", irq1, irq3);
    end
    idle(2);
    wr_reg(8'h14, 8'h01);
    tick();
    checks++;
    if (irq1 !== 1'b1 || irq3 !== 1'b1) begin
      errors++; $display("FAIL set_wins_over_w1c got %b/%b exp 1", irq1, irq3);
    end
    read_chk(8'h14, 8'h01, 1'b1, 1'b1, 1'b1);
    wr_reg(8'h10, 8'h00);
  endtask

  task automatic test_overflow();
    timer_scenario(3'b001, 8'h02, 8'h00, 8'hFE, 6);
  endtask

  task automatic test_back_to_back();
    logic e1, e3;
    logic [7:0] d1, d3;
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h12, 8'h3C);
    tick();
    rd = 1'b1; wr = 1'b1; addr = 8'h12; dout = 8'hAA;
    tick();
    rd = 1'b1; addr = 8'h12;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      e1 = (k == 1);
      e3 = (k == 3);
      d1 = e1 ? 8'h3C : 8'h00;
      d3 = e3 ? 8'h3C : 8'h00;
      checks++;
      if (bus1.p_rd_done !== e1 || bus1.p_din !== d1) begin
        errors++;
        $display("FAIL b2b_lat1 k=%0d got done=%b din=%h exp done=%b din=%h",
                 k, bus1.p_rd_done, bus1.p_din, e1, d1);
      end
      checks++;
      if (bus3.p_rd_done !== e3 || bus3.p_din !== d3) begin
        errors++;
        $display("FAIL b2b_lat3 k=%0d got done=%b din=%h exp done=%b din=%h",
                 k, bus3.p_rd_done, bus3.p_din, e3, d3);
      end
    end
    read_chk(8'h12, 8'hAA, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h11, 8'h5A);
    wr_reg(8'h13, 8'hC3);
    wr_reg(8'h12, 8'h77);
    read_chk(8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
    read_chk(8'h15, 8'h00, 1'b0, 1'b0, 1'b0);
    wr_reg(8'h15, 8'hFF);
    wr_reg(8'h0F, 8'hFF);
    wr_reg(8'h20, 8'hFF);
    read_chk(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    read_chk(8'h11, 8'h5A, 1'b1, 1'b0, 1'b0);
    read_chk(8'h12, 8'h77, 1'b1, 1'b0, 1'b0);
    read_chk(8'h13, 8'hC3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    tick();
    rd = 1'b1; addr = 8'h11;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("reset_mid_read");
    idle(2);
    chk_outputs_zero("reset_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_outputs_zero("no_done_after_reset");
    end
    read_chk(8'h11, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_rd_clear();
    int cw;
    setup(3'b001, 8'h00, 8'hFF, 8'hFE, cw);
    tick();
    wr_reg(8'h10, 8'h00);
    read_chk(8'h14, 8'h03, 1'b1, 1'b1, 1'b0);
`ifdef PBUS_TIMER_RD_CLEAR_EN
    read_chk(8'h14, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    read_chk(8'h14, 8'h03, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [2:0] ctrl;
    logic [7:0] p, k, c;
    for (int i = 0; i < 14; i++) begin
      ctrl = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0)};
      p = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) c = 8'($urandom_range(0, 255));
      else                           c = 8'hFF - 8'($urandom_range(0, 6));
      k = c + 8'($urandom_range(0, 10));
      timer_scenario(ctrl, p, k, c, int'($urandom_range(0, 30)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_match_irq();
    test_overflow();
    test_back_to_back();
    test_unmapped();
    test_reset_mid_read();
    test_rd_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
